// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit:
// operation and state encodings, iteration count and an operand helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // One shift-add or restoring step per cycle, one step per operand bit.
    localparam int unsigned ITER_COUNT = 32;
    localparam logic [4:0]  LAST_ITER  = 5'(ITER_COUNT - 1);

    // Magnitude of a 32-bit operand; only negative signed values are negated.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Operates on magnitudes (shift-add multiply, restoring divide) in one shared
// 64-bit accumulator and one shared adder, then fixes up signs in FIX.
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rsdata_i,
    input  logic [31:0] rtdata_i,
    input  logic        kill_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        done_o
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [33:0] add_a_s, add_b_s, sum_s;
    logic        add_cin_s;
    logic        op_signed_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quo_fix_s, rem_fix_s;

    // Shared adder: accumulate in MUL, trial-subtract the divisor in DIV.
    always_comb begin
        if (state_q == ST_DIV) begin
            add_a_s   = {1'b0, acc_q[63:31]};
            add_b_s   = ~{2'b00, b_q};
            add_cin_s = 1'b1;
        end else begin
            add_a_s   = {2'b00, acc_q[63:32]};
            add_b_s   = acc_q[0] ? {2'b00, b_q} : 34'd0;
            add_cin_s = 1'b0;
        end
        sum_s = add_a_s + add_b_s + {33'd0, add_cin_s};
    end

    // Sign correction of the magnitude results; divide by zero forces an all-ones quotient.
    always_comb begin
        prod_fix_s = neg_res_q ? (64'd0 - acc_q) : acc_q;
        rem_fix_s  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        if (b_q == 32'd0) begin
            quo_fix_s = 32'hFFFF_FFFF;
        end else begin
            quo_fix_s = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        end
    end

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        b_d         = b_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        is_div_d    = is_div_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        op_signed_s = (op_i == OP_MULT) || (op_i == OP_DIV);

        if (kill_i) begin
            // A flush aborts any work and drops a start offered in the same cycle.
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                acc_d     = {32'd0, mag32(rsdata_i, op_signed_s)};
                                b_d       = mag32(rtdata_i, op_signed_s);
                                neg_res_d = op_signed_s && (rsdata_i[31] ^ rtdata_i[31]);
                                neg_rem_d = op_signed_s && rsdata_i[31];
                                is_div_d  = (op_i == OP_DIV) || (op_i == OP_DIVU);
                                cnt_d     = 5'd0;
                                state_d   = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? ST_DIV : ST_MUL;
                            end
                            OP_MTHI: hi_d = rsdata_i;
                            OP_MTLO: lo_d = rsdata_i;
                            default: state_d = ST_IDLE;
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_d = {sum_s[32:0], acc_q[31:1]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
                ST_DIV: begin
                    // Negative trial difference means restore: keep the shifted remainder.
                    if (sum_s[33]) begin
                        acc_d = {acc_q[62:0], 1'b0};
                    end else begin
                        acc_d = {sum_s[31:0], acc_q[30:0], 1'b1};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
                ST_FIX: begin
                    if (is_div_q) begin
                        hi_d = rem_fix_s;
                        lo_d = quo_fix_s;
                    end else begin
                        hi_d = prod_fix_s[63:32];
                        lo_d = prod_fix_s[31:0];
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            b_q       <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random
// mul/div operations checked against an arithmetic reference model.
module tb_ex_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rsdata_i;
    logic [31:0] rtdata_i;
    logic        kill_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    ex_muldiv dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .rsdata_i (rsdata_i),
        .rtdata_i (rtdata_i),
        .kill_i   (kill_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: HI/LO from plain 64-bit arithmetic on the architectural operands.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = 32'd0;
        lo = 32'd0;
        if (op == 3'd1) begin
            sq = sa * sb;
            hi = sq[63:32];
            lo = sq[31:0];
        end else if (op == 3'd2) begin
            uq = ua * ub;
            hi = uq[63:32];
            lo = uq[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == 3'd3) begin
            sq = sa / sb;
            sr = sa % sb;
            hi = sr[31:0];
            lo = sq[31:0];
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            hi = ur[31:0];
            lo = uq[31:0];
        end
    endfunction

    // Present one start for a single edge, then return #1 after that edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        start_i  = 1'b1;
        op_i     = op;
        rsdata_i = a;
        rtdata_i = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        op_i    = 3'd0;
    endtask

    // Count edges until done_o is seen (bounded); lat = -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string name, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_hi, exp_lo;
        int lat;
        ref_op(op, a, b, exp_hi, exp_lo);
        issue(op, a, b);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy_o);
        end
        wait_done(lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 33", name, lat);
        end
        checks++;
        if (hi_o !== exp_hi || lo_o !== exp_lo) begin
            errors++;
            $display("FAIL %s result a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
                     name, a, b, hi_o, lo_o, exp_hi, exp_lo);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_done: got %b expected 0", name, busy_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width: got %b expected 0", name, done_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; kill_i = 1'b1; op_i = 3'd1;
        rsdata_i = 32'h1234_5678; rtdata_i = 32'h9;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0; start_i = 1'b0; kill_i = 1'b0; op_i = 3'd0;
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b expected 0 0 0 0",
                     hi_o, lo_o, busy_o, done_o);
        end
    endtask

    task automatic test_mul();
        run_and_check("mult_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        run_and_check("multu_same", 3'd2, 32'hFFFF_FFFE, 32'h0000_0003);
        run_and_check("mult_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run_and_check("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_div();
        run_and_check("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2);
        run_and_check("divu_100_7", 3'd4, 32'd100, 32'd7);
        run_and_check("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE);
        run_and_check("divu_big", 3'd4, 32'hFFFF_FFFF, 32'h8000_0001);
    endtask

    task automatic test_div_special();
        run_and_check("divu_by_zero", 3'd4, 32'h0000_1234, 32'd0);
        run_and_check("div_neg_by_zero", 3'd3, 32'hFFFF_FF00, 32'd0);
        run_and_check("div_overflow", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] old_lo;
        old_lo = lo_o;
        issue(3'd5, 32'hDEAD_BEEF, 32'h0);
        checks++;
        if (hi_o !== 32'hDEAD_BEEF || lo_o !== old_lo || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b expected hi=deadbeef lo=%h busy=0 done=0",
                     hi_o, lo_o, busy_o, done_o, old_lo);
        end
        issue(3'd6, 32'hCAFE_F00D, 32'h0);
        checks++;
        if (lo_o !== 32'hCAFE_F00D || hi_o !== 32'hDEAD_BEEF || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b expected hi=deadbeef lo=cafef00d busy=0 done=0",
                     hi_o, lo_o, busy_o, done_o);
        end
        // NOP and reserved opcodes leave everything untouched.
        issue(3'd0, 32'h1111_1111, 32'h2);
        issue(3'd7, 32'h3333_3333, 32'h4);
        checks++;
        if (hi_o !== 32'hDEAD_BEEF || lo_o !== 32'hCAFE_F00D || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL nop_rsvd: got hi=%h lo=%h busy=%b expected deadbeef cafef00d 0", hi_o, lo_o, busy_o);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        issue(3'd1, 32'h0001_0000, 32'hFFFF_0000);
        repeat (4) @(posedge clk_i);
        issue(3'd4, 32'd50, 32'd3);
        wait_done(lat);
        checks++;
        if (lat !== 28) begin
            errors++;
            $display("FAIL start_while_busy latency: got %0d expected 28", lat);
        end
        checks++;
        if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'h0000_0000) begin
            errors++;
            $display("FAIL start_while_busy result: got hi=%h lo=%h expected ffffffff 00000000", hi_o, lo_o);
        end
    endtask

    task automatic test_kill();
        logic [31:0] hi0, lo0;
        int lat;
        hi0 = hi_o;
        lo0 = lo_o;
        issue(3'd3, 32'd1000, 32'd7);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_to_idle: got busy=%b expected 0", busy_o);
        end
        wait_done(lat);
        checks++;
        if (lat !== -1 || hi_o !== hi0 || lo_o !== lo0) begin
            errors++;
            $display("FAIL kill_no_result: got done_at=%0d hi=%h lo=%h expected none %h %h",
                     lat, hi_o, lo_o, hi0, lo0);
        end
        // Kill together with a start in IDLE drops the start.
        @(negedge clk_i);
        kill_i = 1'b1; start_i = 1'b1; op_i = 3'd5; rsdata_i = 32'h5555_AAAA;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0; start_i = 1'b0; op_i = 3'd0;
        checks++;
        if (busy_o !== 1'b0 || hi_o !== hi0) begin
            errors++;
            $display("FAIL kill_beats_start: got busy=%b hi=%h expected 0 %h", busy_o, hi_o, hi0);
        end
    endtask

    task automatic test_reset_mid();
        issue(3'd1, 32'h0000_0123, 32'h0000_0456);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b expected 0 0 0 0",
                     hi_o, lo_o, busy_o, done_o);
        end
        run_and_check("multu_after_reset", 3'd2, 32'd3, 32'd4);
        checks++;
        if (lo_o !== 32'd12) begin
            errors++;
            $display("FAIL multu_after_reset lo: got %h expected 0000000c", lo_o);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int n = 0; n < 24; n++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: b = $urandom & 32'h0000_FFFF;
                default: b = $urandom;
            endcase
            run_and_check("random", op, a, b);
        end
    endtask

    initial begin
        start_i = 1'b0; kill_i = 1'b0; op_i = 3'd0;
        rsdata_i = 32'd0; rtdata_i = 32'd0; rst_i = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_mthi_mtlo();
        test_ignore_start();
        test_kill();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The module SHALL have one clock, clk_i; reset rst_i SHALL be synchronous and active-high.
REQ-002 Ports SHALL be:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  op_i valid from ID_EX this cycle.
- op_i  in  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- rsdata_i  in  32  operand A / dividend / MTHI-MTLO source.
- rtdata_i  in  32  operand B / divisor.
- kill_i  in  1  abort the in-flight operation (pipeline flush).
- hi_o  out  32  architectural HI register.
- lo_o  out  32  architectural LO register.
- busy_o  out  1  operation in flight; the hazard unit stalls MFHI/MFLO and new mul/div while high.
- done_o  out  1  one-cycle pulse when HI/LO receive a mul/div result.

Function
REQ-003 States SHALL be IDLE, MUL, DIV and FIX; busy_o SHALL equal (state != IDLE).
REQ-004 In IDLE with start_i=1 and op_i in {1,2,3,4}, the block SHALL capture operand magnitudes, result-sign flags and op at edge N, enter MUL or DIV, and clear a 5-bit iteration counter.
REQ-005 MUL SHALL perform one shift-add step per cycle for 32 cycles using a 64-bit accumulator, then enter FIX.
REQ-006 DIV SHALL perform one restoring-division step per cycle for 32 cycles, then enter FIX.
REQ-007 FIX SHALL apply sign correction, write HI/LO, pulse done_o and return to IDLE; HI/LO and done_o SHALL be valid after edge N+33.
REQ-008 MULT/MULTU SHALL produce HI = product[63:32] and LO = product[31:0] (signed or unsigned, respectively).
REQ-009 DIV/DIVU SHALL produce LO = quotient and HI = remainder; signed quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-010 Divide by zero SHALL produce LO = 0xFFFFFFFF and HI = dividend, taking the full 33-cycle latency.
REQ-011 Signed 0x80000000 / 0xFFFFFFFF SHALL produce LO = 0x80000000 and HI = 0.
REQ-012 In IDLE, MTHI/MTLO with start_i=1 SHALL write rsdata_i to HI or LO at that edge, with no busy_o and no done_o.
REQ-013 start_i while busy_o=1 SHALL be ignored.
REQ-014 kill_i=1 in a non-IDLE state SHALL return to IDLE at the next edge with HI/LO unchanged and no done_o.
REQ-015 If kill_i and start_i are both 1 in IDLE, kill_i SHALL win and the start SHALL be dropped.
REQ-016 NOP/reserved ops SHALL cause no state change.
REQ-017 hi_o/lo_o SHALL be driven directly from registers.

Reset
REQ-018 rst_i=1 at a rising edge SHALL force state=IDLE, counter=0, HI=0, LO=0, busy_o=0 and done_o=0, overriding start_i and kill_i.
REQ-019 Reset mid-operation SHALL discard the operation, and the next edge after reset release SHALL accept a new start_i.

Structure
REQ-020 Op encodings, state encodings and the iteration count (32) SHALL reside in the shared package muldiv_pkg.
REQ-021 The block SHALL be a single module with no sub-module; the accumulator and datapath SHALL be shared between MUL and DIV.

Verification
REQ-022 The bench SHALL cover: MULT 0xFFFFFFFE x 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA; done_o at N+33 in both cases.
REQ-023 The bench SHALL cover: DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2.
REQ-024 The bench SHALL cover: DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-025 The bench SHALL cover: MTHI 0xDEADBEEF -> hi_o=0xDEADBEEF the next cycle, busy_o stays 0; a second start_i during MULT is ignored and the first result is intact.
REQ-026 The bench SHALL cover: kill_i asserted at cycle 10 of a DIV -> IDLE next edge, HI/LO unchanged, no done_o.
REQ-027 The bench SHALL cover: rst_i at cycle 5 of a MULT -> HI=LO=0, busy_o=0; a new MULTU 3 x 4 started immediately after -> LO=12.
